// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU clients and the arbiter.
// master = client side, slave = arbiter side.
interface alu_arbiter_if;
  logic        req_valid_0;
  logic        req_valid_1;
  logic        req_ready_0;
  logic        req_ready_1;
  logic [31:0] req_src1_0;
  logic [31:0] req_src1_1;
  logic [31:0] req_src2_0;
  logic [31:0] req_src2_1;
  logic [11:0] req_ctrl_0;
  logic [11:0] req_ctrl_1;
  logic        rsp_valid_0;
  logic        rsp_valid_1;
  logic        rsp_ready_0;
  logic        rsp_ready_1;
  logic [31:0] rsp_result;

  modport master (
    output req_valid_0, req_valid_1,
    output req_src1_0, req_src1_1, req_src2_0, req_src2_1,
    output req_ctrl_0, req_ctrl_1,
    output rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1,
    input  rsp_valid_0, rsp_valid_1, rsp_result
  );

  modport slave (
    input  req_valid_0, req_valid_1,
    input  req_src1_0, req_src1_1, req_src2_0, req_src2_1,
    input  req_ctrl_0, req_ctrl_1,
    input  rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1,
    output rsp_valid_0, rsp_valid_1, rsp_result
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU.
// One operation in flight at a time: IDLE (grant) -> EXEC (ALU) -> RESP (hold result).
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.slave  bus,
  output logic [31:0]   alu_src1,
  output logic [31:0]   alu_src2,
  output logic [11:0]   alu_control,
  input  logic [31:0]   alu_result,
  output logic [15:0]   op_count
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CTRL_W = 12;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [DATA_W-1:0]   src1_q;
  logic [DATA_W-1:0]   src2_q;
  logic [CTRL_W-1:0]   ctrl_q;
  logic [DATA_W-1:0]   result_q;
  logic [CNT_W-1:0]    op_count_q;
  logic                owner_q;
  logic                last_grant_q;

  logic                grant_vld;
  logic                grant_id;
  logic                rsp_hs;
  logic                owner_rsp_ready;

  assign owner_rsp_ready = owner_q ? bus.rsp_ready_1 : bus.rsp_ready_0;

  // Next state, grant selection and response handshake detection
  always_comb begin
    state_d   = state_q;
    grant_vld = 1'b0;
    grant_id  = 1'b0;
    rsp_hs    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rst && (bus.req_valid_0 || bus.req_valid_1)) begin
          grant_vld = 1'b1;
          if (bus.req_valid_0 && bus.req_valid_1) begin
            grant_id = FIXED_PRIO ? 1'b0 : ~last_grant_q;
          end else begin
            grant_id = bus.req_valid_1;
          end
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        if (owner_rsp_ready) begin
          rsp_hs  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant is combinational so the handshake completes in the requesting cycle
  assign bus.req_ready_0 = grant_vld && !grant_id;
  assign bus.req_ready_1 = grant_vld && grant_id;

  assign bus.rsp_valid_0 = (state_q == RESP) && !owner_q;
  assign bus.rsp_valid_1 = (state_q == RESP) && owner_q;
  assign bus.rsp_result  = result_q;

  assign alu_src1    = src1_q;
  assign alu_src2    = src2_q;
  assign alu_control = (state_q == EXEC) ? ctrl_q : CTRL_W'(0);
  assign op_count    = op_count_q;

  // Pointer resets to 1 so requester 0 wins the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      src1_q       <= DATA_W'(0);
      src2_q       <= DATA_W'(0);
      ctrl_q       <= CTRL_W'(0);
      result_q     <= DATA_W'(0);
      op_count_q   <= CNT_W'(0);
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (grant_vld) begin
        src1_q       <= grant_id ? bus.req_src1_1 : bus.req_src1_0;
        src2_q       <= grant_id ? bus.req_src2_1 : bus.req_src2_0;
        ctrl_q       <= grant_id ? bus.req_ctrl_1 : bus.req_ctrl_0;
        owner_q      <= grant_id;
        last_grant_q <= grant_id;
      end
      if (state_q == EXEC) begin
        result_q <= alu_result;
      end
      if (rsp_hs) begin
        op_count_q <= op_count_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: round-robin instance plus a fixed-priority instance,
// each with its own reference ALU on the alu_* ports.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  alu_arbiter_if a ();
  alu_arbiter_if b ();

  logic [31:0] a_alu_src1, a_alu_src2, a_alu_result;
  logic [11:0] a_alu_control;
  logic [15:0] a_op_count;
  logic [31:0] b_alu_src1, b_alu_src2, b_alu_result;
  logic [11:0] b_alu_control;
  logic [15:0] b_op_count;

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .bus(a.slave),
    .alu_src1(a_alu_src1), .alu_src2(a_alu_src2), .alu_control(a_alu_control),
    .alu_result(a_alu_result), .op_count(a_op_count)
  );

  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .bus(b.slave),
    .alu_src1(b_alu_src1), .alu_src2(b_alu_src2), .alu_control(b_alu_control),
    .alu_result(b_alu_result), .op_count(b_op_count)
  );

  function automatic logic [31:0] alu_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic [11:0] c);
    logic [31:0] r;
    if (c == 12'h000 || c[11]) r = x + y;
    else if (c[10]) r = x - y;
    else if (c[9])  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
    else if (c[8])  r = (x < y) ? 32'd1 : 32'd0;
    else if (c[7])  r = x & y;
    else if (c[6])  r = ~(x | y);
    else if (c[5])  r = x | y;
    else if (c[4])  r = x ^ y;
    else if (c[3])  r = x << y[4:0];
    else if (c[2])  r = x >> y[4:0];
    else if (c[1])  r = 32'($signed(x) >>> y[4:0]);
    else            r = {y[15:0], 16'h0000};
    return r;
  endfunction

  assign a_alu_result = alu_fn(a_alu_src1, a_alu_src2, a_alu_control);
  assign b_alu_result = alu_fn(b_alu_src1, b_alu_src2, b_alu_control);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int k, input logic v, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [11:0] c);
    if (k == 0) begin
      a.req_valid_0 = v; a.req_src1_0 = s1; a.req_src2_0 = s2; a.req_ctrl_0 = c;
    end else begin
      a.req_valid_1 = v; a.req_src1_1 = s1; a.req_src2_1 = s2; a.req_ctrl_1 = c;
    end
  endtask

  // Single-requester operation on the round-robin instance, checked cycle by cycle
  task automatic do_single(input int k, input logic [31:0] s1, input logic [31:0] s2,
                           input logic [11:0] c, input logic [31:0] exp,
                           input logic [15:0] cnt_before);
    logic [15:0] cnt_after;
    cnt_after = cnt_before + 16'd1;
    a.rsp_ready_0 = 1'b1;
    a.rsp_ready_1 = 1'b1;
    set_a(k, 1'b1, s1, s2, c);
    #1;
    chk("single_ready_own", (k == 0) ? a.req_ready_0 : a.req_ready_1, 1);
    chk("single_ready_other", (k == 0) ? a.req_ready_1 : a.req_ready_0, 0);
    tick;
    chk("single_exec_ready", (k == 0) ? a.req_ready_0 : a.req_ready_1, 0);
    set_a(k, 1'b0, 32'h0, 32'h0, 12'h0);
    chk("single_exec_ctrl", a_alu_control, c);
    chk("single_exec_src1", a_alu_src1, s1);
    chk("single_exec_src2", a_alu_src2, s2);
    tick;
    chk("single_rsp_valid", (k == 0) ? a.rsp_valid_0 : a.rsp_valid_1, 1);
    chk("single_rsp_other", (k == 0) ? a.rsp_valid_1 : a.rsp_valid_0, 0);
    chk("single_rsp_result", a.rsp_result, exp);
    chk("single_rsp_ctrl", a_alu_control, 0);
    chk("single_cnt_before", a_op_count, cnt_before);
    tick;
    chk("single_done_valid", (k == 0) ? a.rsp_valid_0 : a.rsp_valid_1, 0);
    chk("single_cnt_after", a_op_count, cnt_after);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    set_a(0, 1'b0, 32'h0, 32'h0, 12'h0);
    set_a(1, 1'b0, 32'h0, 32'h0, 12'h0);
    a.rsp_ready_0 = 1'b0; a.rsp_ready_1 = 1'b0;
    b.req_valid_0 = 1'b0; b.req_valid_1 = 1'b0;
    b.req_src1_0 = 32'h0; b.req_src2_0 = 32'h0; b.req_ctrl_0 = 12'h0;
    b.req_src1_1 = 32'h0; b.req_src2_1 = 32'h0; b.req_ctrl_1 = 12'h0;
    b.rsp_ready_0 = 1'b1; b.rsp_ready_1 = 1'b1;

    // Reset state, with a request pending that must not be granted
    tick; tick;
    a.req_valid_0 = 1'b1;
    #1;
    chk("rst_ready_0", a.req_ready_0, 0);
    chk("rst_rsp_valid_0", a.rsp_valid_0, 0);
    chk("rst_rsp_result", a.rsp_result, 0);
    chk("rst_alu_control", a_alu_control, 0);
    chk("rst_alu_src1", a_alu_src1, 0);
    chk("rst_op_count", a_op_count, 0);
    a.req_valid_0 = 1'b0;
    rst = 1'b0;

    // Contention straight after reset: requester 0 first, then requester 1
    a.rsp_ready_0 = 1'b1; a.rsp_ready_1 = 1'b1;
    set_a(0, 1'b1, 32'd10, 32'd4, 12'h400);
    set_a(1, 1'b1, 32'h80000000, 32'd4, 12'h002);
    #1;
    chk("c1_ready_0", a.req_ready_0, 1);
    chk("c1_ready_1", a.req_ready_1, 0);
    tick;
    a.req_valid_0 = 1'b0;
    chk("c1_exec_ready_1", a.req_ready_1, 0);
    chk("c1_exec_ctrl", a_alu_control, 12'h400);
    tick;
    chk("c1_rsp_valid_0", a.rsp_valid_0, 1);
    chk("c1_rsp_valid_1", a.rsp_valid_1, 0);
    chk("c1_rsp_result", a.rsp_result, 32'd6);
    tick;
    chk("c1_cnt", a_op_count, 1);
    chk("c1_second_ready_1", a.req_ready_1, 1);
    tick;
    a.req_valid_1 = 1'b0;
    chk("c1_second_ctrl", a_alu_control, 12'h002);
    tick;
    chk("c1_second_rsp_valid_1", a.rsp_valid_1, 1);
    chk("c1_second_result", a.rsp_result, 32'hF8000000);
    tick;
    chk("c1_second_cnt", a_op_count, 2);

    // Lone add from requester 0; moves the pointer to 0
    do_single(0, 32'd5, 32'd3, 12'h800, 32'd8, 16'd2);

    // Repeat contention now favours requester 1
    set_a(0, 1'b1, 32'h0000F0F0, 32'h0000FF00, 12'h080);
    set_a(1, 1'b1, 32'hFFFFFFFF, 32'd1, 12'h200);
    #1;
    chk("c2_ready_1", a.req_ready_1, 1);
    chk("c2_ready_0", a.req_ready_0, 0);
    tick;
    a.req_valid_1 = 1'b0;
    tick;
    chk("c2_rsp_valid_1", a.rsp_valid_1, 1);
    chk("c2_rsp_valid_0", a.rsp_valid_0, 0);
    chk("c2_rsp_result", a.rsp_result, 32'd1);
    tick;
    chk("c2_cnt", a_op_count, 4);
    chk("c2_second_ready_0", a.req_ready_0, 1);
    tick;
    a.req_valid_0 = 1'b0;
    tick;
    chk("c2_second_rsp_valid_0", a.rsp_valid_0, 1);
    chk("c2_second_result", a.rsp_result, 32'h0000F000);
    tick;
    chk("c2_second_cnt", a_op_count, 5);

    // Backpressure on requester 1; requester 0's rsp_ready must be ignored
    a.rsp_ready_1 = 1'b0;
    a.rsp_ready_0 = 1'b1;
    set_a(1, 1'b1, 32'd1, 32'd2, 12'h100);
    #1;
    chk("bp_ready_1", a.req_ready_1, 1);
    tick;
    a.req_valid_1 = 1'b0;
    tick;
    a.req_valid_0 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid_1", a.rsp_valid_1, 1);
      chk("bp_rsp_result", a.rsp_result, 32'd1);
      chk("bp_ready_0", a.req_ready_0, 0);
      chk("bp_ready_1", a.req_ready_1, 0);
      chk("bp_cnt", a_op_count, 5);
      tick;
    end
    a.rsp_ready_1 = 1'b1;
    tick;
    chk("bp_done_valid_1", a.rsp_valid_1, 0);
    chk("bp_done_cnt", a_op_count, 6);
    a.req_valid_0 = 1'b0;

    // ctrl = 0 reaches the ALU unchanged
    do_single(0, 32'd7, 32'd9, 12'h000, 32'd16, 16'd6);

    // Reset pulsed during EXEC drops the operation
    set_a(0, 1'b1, 32'd1, 32'd1, 12'h800);
    #1;
    chk("mid_ready_0", a.req_ready_0, 1);
    tick;
    a.req_valid_0 = 1'b0;
    chk("mid_exec_ctrl", a_alu_control, 12'h800);
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", a_alu_control, 0);
    chk("mid_rst_cnt", a_op_count, 0);
    chk("mid_rst_rsp_valid_0", a.rsp_valid_0, 0);
    tick;
    rst = 1'b0;
    tick;
    chk("mid_after_rsp_valid_0", a.rsp_valid_0, 0);
    chk("mid_after_rsp_valid_1", a.rsp_valid_1, 0);
    chk("mid_after_cnt", a_op_count, 0);
    do_single(1, 32'd100, 32'd23, 12'h800, 32'd123, 16'd0);

    // Counter wrap from 16'hFFFF
    force dut.op_count_q = 16'hFFFF;
    #1;
    release dut.op_count_q;
    #1;
    chk("wrap_preload", a_op_count, 16'hFFFF);
    do_single(0, 32'h0, 32'h0, 12'h040, 32'hFFFFFFFF, 16'hFFFF);

    // Fixed priority: requester 0 wins while both stay valid
    b.req_valid_0 = 1'b1; b.req_src1_0 = 32'd1; b.req_src2_0 = 32'd2; b.req_ctrl_0 = 12'h800;
    b.req_valid_1 = 1'b1; b.req_src1_1 = 32'hF0; b.req_src2_1 = 32'h3C; b.req_ctrl_1 = 12'h010;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fp_ready_0", b.req_ready_0, 1);
      chk("fp_ready_1", b.req_ready_1, 0);
      tick;
      tick;
      chk("fp_rsp_valid_0", b.rsp_valid_0, 1);
      chk("fp_rsp_result_0", b.rsp_result, 32'd3);
      tick;
    end
    chk("fp_cnt3", b_op_count, 3);
    b.req_valid_0 = 1'b0;
    #1;
    chk("fp_late_ready_1", b.req_ready_1, 1);
    chk("fp_late_ready_0", b.req_ready_0, 0);
    tick;
    b.req_valid_1 = 1'b0;
    tick;
    chk("fp_rsp_valid_1", b.rsp_valid_1, 1);
    chk("fp_rsp_result_1", b.rsp_result, 32'h000000CC);
    tick;
    chk("fp_cnt4", b_op_count, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
